rr_rsp_demux: RTL
=================

# rr_rsp_demux

Response-return demultiplexer for the round-robin request arbiter: records the winning input index of every accepted request in an in-order queue, then steers each returning response to the originating requester. It sits beside the arbiter tree on the slave side of a shared port. Request grants go N:1 through the arbiter; responses come back 1:N through this block. Responses are required to return in request order; no IDs travel with them.

## Interface
- NumOut, 4: number of requesters (response outputs); ≥1.
- DataWidth, 32: response payload width.
- MaxTrans, 4: maximum outstanding transactions (queue depth); ≥1, need not be a power of two.
- IdxWidth (derived): `NumOut>1 ? $clog2(NumOut) : 1`.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of all outstanding state.
- req_valid_i  in  1  request handed downstream this cycle (arbiter req_o & gnt_i).
- req_idx_i  in  IdxWidth  requester index of that request (arbiter idx_o).
- req_ready_o  out  1  queue can record a request; ANDed into the arbiter's gnt_i.
- rsp_valid_i  in  1  response valid from downstream.
- rsp_ready_o  out  1  response accepted.
- rsp_data_i  in  DataWidth  response payload.
- rsp_valid_o  out  NumOut  one-hot-or-zero response valid per requester.
- rsp_ready_i  in  NumOut  per-requester ready.
- rsp_data_o  out  DataWidth  payload broadcast to all requesters (= rsp_data_i).
- outstanding_o  out  $clog2(MaxTrans+1)  current queue occupancy.
- err_o  out  1  single-cycle pulse on a dropped response (illegal index).

## Operation
- Queue: circular buffer of MaxTrans entries of IdxWidth, with write pointer, read pointer, and occupancy counter. Pointers wrap from MaxTrans-1 to 0.
- Push: `req_valid_i & req_ready_o` writes req_idx_i at the write pointer.
- req_ready_o = (count != MaxTrans). There is no full-queue bypass, so req_ready_o never depends on the response path.
- Head index h = entry at the read pointer. It is valid only when count != 0.
- Routing when count != 0 and h < NumOut:
  - rsp_valid_o[h] = rsp_valid_i; all other bits 0.
  - rsp_ready_o = rsp_ready_i[h].
- Pop: `rsp_valid_i & rsp_ready_o & count!=0` advances the read pointer.
- Illegal index (h ≥ NumOut, only possible when NumOut is not a power of two):
  - rsp_valid_o = 0 and rsp_ready_o = 1.
  - The response is dropped and popped, and err_o pulses for one cycle.
- Empty (count==0): rsp_valid_o = 0 and rsp_ready_o = 0. An early response stalls; it is never dropped.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any occupancy below full. When full, the pop proceeds and the push is refused.
- flush_i takes priority over push and pop:
  - Next cycle: count=0, pointers=0.
  - A push or pop in the flush cycle is discarded.
  - Combinational outputs in the flush cycle still reflect the pre-flush state.
- Reset is asynchronous and returns all state to the reset values at any point, including mid-transaction.

## Timing
- Reset values: req_ready_o=1, rsp_ready_o=0, rsp_valid_o=0, outstanding_o=0, err_o=0.
- Push at cycle t makes the entry visible at the head in t+1. A response arriving in cycle t to an empty queue is accepted no earlier than t+1.
- The response path is combinational (rsp_valid_i/rsp_ready_i → rsp_valid_o/rsp_ready_o, zero latency). The only storage on it is the index queue.
- outstanding_o is registered and updates the cycle after push/pop.
- err_o is combinational, asserted in the cycle the dropped response handshakes.
- rsp_valid_o is asserted while rsp_valid_i is high; it does not depend on rsp_ready_i.

## Structure
- No shared package entries. Widths are local derived parameters.
- Sub-module: `rr_idx_fifo` holds the pointers, counter, storage, full/empty flags and flush. It is parameterised by depth and width.
- Top level holds the head decode, the one-hot valid steering, ready select and illegal-index detection.

## Test plan
- Single transaction, NumOut=4: push idx 2 at t0, rsp_valid_i at t0 and t1.
  - t0: stalled.
  - t1: rsp_valid_o=4'b0100, handshake; outstanding_o 1→0.
- Fill, MaxTrans=4: push indices 3,1,0,2.
  - req_ready_o=0 after 4th push.
  - Responses route in order 3,1,0,2.
  - Push and pop in the same full cycle: pop taken, push refused, count 4→3.
- Back-pressure: head idx 1, rsp_ready_i=4'b1101.
  - rsp_valid_o=4'b0010 and rsp_ready_o=0 held.
  - Raise bit 1: pop in that cycle.
- Wrap: MaxTrans=3, 10 interleaved push/pop pairs with indices 0..3 cycling. Every response reaches the correct output and pointers wrap with no loss.
- Illegal index: NumOut=3, push idx 3. Response is dropped with rsp_ready_o=1, rsp_valid_o=0 and err_o pulsed once.
- Flush/reset: 3 outstanding, assert flush_i. Next cycle outstanding_o=0, req_ready_o=1, and a response stalls. Repeat with rst_ni mid-handshake and check the reset values.

Source files
------------

// File: rtl/rr_rsp_demux_pkg.sv
// rr_rsp_demux_pkg: helper for deriving index widths in the response demux slice
package rr_rsp_demux_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_idx_fifo.sv
// rr_idx_fifo: circular index queue with occupancy counter, full/empty flags and flush
module rr_idx_fifo
    import rr_rsp_demux_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == DepthCnt);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    // Next state: flush overrides everything; pushes refused when full, pops ignored when empty
    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        mem_d   = mem_q;
        if (do_push) mem_d[wptr_q] = data_i;
        wptr_d  = flush_i ? '0 : do_push ? ((wptr_q == LastPtr) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d  = flush_i ? '0 : do_pop ? ((rptr_q == LastPtr) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d   = flush_i ? '0 : cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rr_rsp_demux.sv
// rr_rsp_demux: steers in-order responses back to the requester recorded at request time
module rr_rsp_demux
    import rr_rsp_demux_pkg::*;
#(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 4,
    localparam int unsigned IdxWidth = idx_width(NumOut),
    localparam int unsigned OutW     = $clog2(MaxTrans + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    input  logic [IdxWidth-1:0]  req_idx_i,
    output logic                 req_ready_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic [NumOut-1:0]    rsp_valid_o,
    input  logic [NumOut-1:0]    rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic [OutW-1:0]      outstanding_o,
    output logic                 err_o
);

    localparam logic [IdxWidth:0] NumOutL = (IdxWidth + 1)'(NumOut);

    logic [IdxWidth-1:0] head;
    logic                empty, full, legal, pop;

    rr_idx_fifo #(
        .Depth (MaxTrans),
        .Width (IdxWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (req_valid_i),
        .data_i  (req_idx_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    assign req_ready_o = ~full;
    assign rsp_data_o  = rsp_data_i;
    assign legal       = ({1'b0, head} < NumOutL);
    assign pop         = rsp_valid_i & rsp_ready_o;

    // Head decode: route to the recorded requester, swallow illegal indices, stall when empty
    always_comb begin
        rsp_valid_o = '0;
        if (!empty && legal) rsp_valid_o[head] = rsp_valid_i;
        rsp_ready_o = empty ? 1'b0 : legal ? rsp_ready_i[head] : 1'b1;
        err_o       = rsp_valid_i & ~empty & ~legal;
    end

endmodule
